// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the load/store initiator.
package mem_access_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    CAPT  = 3'd2,
    WRITE = 3'd3,
    RESP  = 3'd4
  } state_e;

  // True when the access cannot be performed: illegal size or misaligned lane.
  function automatic logic misaligned(size_e size, logic [1:0] lane);
    case (size)
      SZ_HALF: return lane[0];
      SZ_WORD: return lane != 2'b00;
      SZ_ILL:  return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response handshake between the execute stage and the load/store unit.
interface mem_access_unit_if #(
  parameter int N = 5,
  parameter int W = 32
);
  logic         req_valid;
  logic         req_ready;
  logic         req_write;
  logic [1:0]   req_size;
  logic         req_unsigned;
  logic [N+1:0] req_addr;
  logic [W-1:0] req_wdata;
  logic         resp_valid;
  logic [W-1:0] resp_rdata;
  logic         resp_error;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_error
  );
endinterface

// File: rtl/mem_lane_unit.sv
// Little-endian lane logic: load extract/extend and store read-modify-write merge.
module mem_lane_unit
  import mem_access_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] word,
  input  logic [1:0]   lane,
  input  size_e        size,
  input  logic         is_unsigned,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] load_data,
  output logic [W-1:0] merged
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  always_comb begin
    byte_val  = word[8*lane +: 8];
    half_val  = word[16*lane[1] +: 16];
    load_data = word;
    merged    = word;
    case (size)
      SZ_BYTE: begin
        load_data = is_unsigned ? {24'b0, byte_val} : {{24{byte_val[7]}}, byte_val};
        merged[8*lane +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        load_data = is_unsigned ? {16'b0, half_val} : {{16{half_val[15]}}, half_val};
        merged[16*lane[1] +: 16] = wdata[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator in front of a word-addressed data_memory with a registered read port.
// state | meaning: IDLE accept | READ MemRead pulse | CAPT extract/merge | WRITE MemWrite pulse | RESP response
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int W = 32,
  parameter int N = 5
) (
  input  logic               clk,
  input  logic               rst,
  mem_access_unit_if.slave   bus,
  output logic               MemRead,
  output logic               MemWrite,
  output logic [N-1:0]       address,
  output logic [W-1:0]       write_data,
  input  logic [W-1:0]       read_data
);

  state_e       state;
  logic         req_ready;
  logic         resp_valid;
  logic         resp_error;
  logic [W-1:0] resp_rdata;
  logic         lat_write;
  size_e        lat_size;
  logic         lat_unsigned;
  logic [1:0]   lat_lane;
  logic [W-1:0] lat_wdata;
  logic [W-1:0] load_data;
  logic [W-1:0] merged;
  size_e        in_size;

  assign in_size        = size_e'(bus.req_size);
  assign bus.req_ready  = req_ready;
  assign bus.resp_valid = resp_valid;
  assign bus.resp_error = resp_error;
  assign bus.resp_rdata = resp_rdata;

  mem_lane_unit #(.W(W)) u_lane (
    .word        (read_data),
    .lane        (lat_lane),
    .size        (lat_size),
    .is_unsigned (lat_unsigned),
    .wdata       (lat_wdata),
    .load_data   (load_data),
    .merged      (merged)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      req_ready    <= 1'b0;
      resp_valid   <= 1'b0;
      resp_error   <= 1'b0;
      resp_rdata   <= '0;
      MemRead      <= 1'b0;
      MemWrite     <= 1'b0;
      address      <= '0;
      write_data   <= '0;
      lat_write    <= 1'b0;
      lat_size     <= SZ_BYTE;
      lat_unsigned <= 1'b0;
      lat_lane     <= 2'b00;
      lat_wdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid && req_ready) begin
            req_ready    <= 1'b0;
            lat_write    <= bus.req_write;
            lat_size     <= in_size;
            lat_unsigned <= bus.req_unsigned;
            lat_lane     <= bus.req_addr[1:0];
            lat_wdata    <= bus.req_wdata;
            address      <= bus.req_addr[N+1:2];
            if (misaligned(in_size, bus.req_addr[1:0])) begin
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
              resp_rdata <= '0;
              state      <= RESP;
            end else if (bus.req_write && in_size == SZ_WORD) begin
              write_data <= bus.req_wdata;
              MemWrite   <= 1'b1;
              state      <= WRITE;
            end else begin
              // Loads and sub-word stores both need the current word first.
              MemRead <= 1'b1;
              state   <= READ;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        READ: begin
          MemRead <= 1'b0;
          state   <= CAPT;
        end
        CAPT: begin
          if (lat_write) begin
            write_data <= merged;
            MemWrite   <= 1'b1;
            state      <= WRITE;
          end else begin
            resp_rdata <= load_data;
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end
        WRITE: begin
          MemWrite   <= 1'b0;
          resp_valid <= 1'b1;
          resp_rdata <= '0;
          state      <= RESP;
        end
        RESP: begin
          resp_valid <= 1'b0;
          resp_error <= 1'b0;
          resp_rdata <= '0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit with a behavioural data_memory and a lane-arithmetic reference model.
module tb_mem_access_unit;
  import mem_access_pkg::*;

  localparam int W = 32;
  localparam int N = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         MemRead, MemWrite;
  logic [N-1:0] address;
  logic [W-1:0] write_data;
  logic [W-1:0] read_data;

  int checks = 0;
  int failures = 0;
  int overlap = 0;

  mem_access_unit_if #(.N(N), .W(W)) bus ();

  mem_access_unit #(.W(W), .N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data)
  );

  always #5 clk = ~clk;

  // data_memory: registered read, write on MemWrite, plus a preload port.
  logic [W-1:0] mem [0:31];
  logic         bd_we = 1'b0;
  logic [N-1:0] bd_addr = '0;
  logic [W-1:0] bd_data = '0;
  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (MemWrite) mem[address] <= write_data;
    if (MemRead) read_data <= mem[address];
  end

  always @(negedge clk) if (MemRead && MemWrite) overlap++;

  logic [31:0] ref_mem [0:31];

  task automatic model(input bit wr, input logic [1:0] sz, input bit uns, input logic [6:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output logic err,
                       output int lat, output int nrd, output int nwr, output logic [31:0] wdat);
    int w, k;
    logic [31:0] old, mask, val;
    w = int'(a[6:2]);
    k = int'(a[1:0]);
    err = (sz == 2'd3) || (sz == 2'd1 && (k % 2) != 0) || (sz == 2'd2 && k != 0);
    rd = 0; nrd = 0; nwr = 0; wdat = 0; old = ref_mem[w];
    if (err) lat = 1;
    else if (!wr) begin
      lat = 3; nrd = 1;
      if (sz == 2'd0) begin
        val = (old >> (8*k)) & 32'hFF;
        if (!uns && val >= 32'h80) val = val | 32'hFFFFFF00;
      end else if (sz == 2'd1) begin
        val = (old >> (8*k)) & 32'hFFFF;
        if (!uns && val >= 32'h8000) val = val | 32'hFFFF0000;
      end else val = old;
      rd = val;
    end else begin
      nwr = 1;
      if (sz == 2'd2) begin
        lat = 2; wdat = wd;
      end else begin
        lat = 4; nrd = 1;
        mask = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << (8*k);
        wdat = (old & ~mask) | ((wd << (8*k)) & mask);
      end
      ref_mem[w] = wdat;
    end
  endtask

  // Issues one request from a negedge; observes the response window cycle by cycle.
  task automatic do_req(input bit wr, input logic [1:0] sz, input bit uns, input logic [6:0] a,
                        input logic [31:0] wd, output logic [31:0] o_rd, output logic o_err,
                        output int o_lat, output int o_nrd, output int o_nwr, output logic [31:0] o_wd,
                        output logic o_rdy1, output logic o_after);
    int t;
    t = 0;
    while (bus.req_ready !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    if (bus.req_ready !== 1'b1) begin
      checks++; failures++;
      $display("FAIL ready_wait: req_ready=%b required 1", bus.req_ready);
    end
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_size = sz;
    bus.req_unsigned = uns; bus.req_addr = a; bus.req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_write = 1'($urandom); bus.req_size = 2'($urandom);
    bus.req_unsigned = 1'($urandom); bus.req_addr = 7'($urandom); bus.req_wdata = $urandom;
    o_rd = 'x; o_err = 1'bx; o_lat = 0; o_nrd = 0; o_nwr = 0; o_wd = 'x;
    o_rdy1 = bus.req_ready;
    for (int c = 1; c <= 12; c++) begin
      if (c > 1) @(negedge clk);
      if (MemRead) o_nrd++;
      if (MemWrite) begin o_nwr++; o_wd = write_data; end
      if (bus.resp_valid) begin
        o_lat = c; o_rd = bus.resp_rdata; o_err = bus.resp_error;
        break;
      end
    end
    @(negedge clk);
    o_after = bus.req_ready && !bus.resp_valid;
  endtask

  task automatic test_reset();
    checks++;
    if ({bus.req_ready, bus.resp_valid, bus.resp_error, MemRead, MemWrite} !== 5'b0 ||
        bus.resp_rdata !== 32'h0 || write_data !== 32'h0 || address !== 5'h0) begin
      failures++;
      $display("FAIL reset_outputs: rdy=%b rv=%b err=%b rd=%b wr=%b rdata=%h wdata=%h addr=%h required all 0",
               bus.req_ready, bus.resp_valid, bus.resp_error, MemRead, MemWrite, bus.resp_rdata, write_data, address);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 1'b0) begin failures++; $display("FAIL reset_release_ready: got %b required 0", bus.req_ready); end
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL ready_after_reset: got %b required 1", bus.req_ready); end
  endtask

  task automatic test_loads();
    logic [31:0] rd, wdo; logic err, r1, ra; int lat, nrd, nwr;
    do_req(1'b0, 2'b00, 1'b0, 7'h0D, 32'h0, rd, err, lat, nrd, nwr, wdo, r1, ra);
    checks++;
    if (rd !== 32'hFFFFFFAA || err !== 1'b0) begin failures++; $display("FAIL sbyte_data: rdata=%h err=%b required ffffffaa 0", rd, err); end
    checks++;
    if (lat != 3 || nrd != 1 || nwr != 0) begin failures++; $display("FAIL sbyte_timing: lat=%0d nrd=%0d nwr=%0d required 3 1 0", lat, nrd, nwr); end
    checks++;
    if (r1 !== 1'b0 || ra !== 1'b1) begin failures++; $display("FAIL sbyte_ready: r1=%b after=%b required 0 1", r1, ra); end
    do_req(1'b0, 2'b01, 1'b1, 7'h0E, 32'h0, rd, err, lat, nrd, nwr, wdo, r1, ra);
    checks++;
    if (rd !== 32'h00008899 || err !== 1'b0 || lat != 3) begin failures++; $display("FAIL uhalf: rdata=%h err=%b lat=%0d required 00008899 0 3", rd, err, lat); end
    do_req(1'b0, 2'b01, 1'b0, 7'h0E, 32'h0, rd, err, lat, nrd, nwr, wdo, r1, ra);
    checks++;
    if (rd !== 32'hFFFF8899 || err !== 1'b0 || lat != 3) begin failures++; $display("FAIL shalf: rdata=%h err=%b lat=%0d required ffff8899 0 3", rd, err, lat); end
  endtask

  task automatic test_errors();
    logic [31:0] rd, wdo; logic err, r1, ra; int lat, nrd, nwr;
    do_req(1'b0, 2'b10, 1'b0, 7'h06, 32'h0, rd, err, lat, nrd, nwr, wdo, r1, ra);
    checks++;
    if (rd !== 32'h0 || err !== 1'b1 || lat != 1 || nrd != 0 || nwr != 0) begin
      failures++; $display("FAIL err_misaligned: rdata=%h err=%b lat=%0d nrd=%0d nwr=%0d required 0 1 1 0 0", rd, err, lat, nrd, nwr);
    end
    do_req(1'b1, 2'b11, 1'b0, 7'h00, 32'hFFFFFFFF, rd, err, lat, nrd, nwr, wdo, r1, ra);
    checks++;
    if (rd !== 32'h0 || err !== 1'b1 || lat != 1 || nrd != 0 || nwr != 0 || ra !== 1'b1) begin
      failures++; $display("FAIL err_illegal: rdata=%h err=%b lat=%0d nrd=%0d nwr=%0d after=%b required 0 1 1 0 0 1", rd, err, lat, nrd, nwr, ra);
    end
  endtask

  task automatic test_reset_rmw();
    logic [31:0] rd, wdo; logic err, r1, ra; int lat, nrd, nwr, bad;
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_addr = 7'h0D; bus.req_wdata = 32'h00000055;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({MemRead, MemWrite, bus.resp_valid, bus.req_ready} !== 4'b0) begin
      failures++; $display("FAIL rmw_abort: rd=%b wr=%b rv=%b rdy=%b required 0000", MemRead, MemWrite, bus.resp_valid, bus.req_ready);
    end
    bad = 0;
    repeat (3) begin @(negedge clk); if (MemWrite || bus.resp_valid || bus.req_ready) bad++; end
    rst = 1'b1;
    #1;
    if (bus.req_ready !== 1'b0) bad++;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL rmw_ready_return: got %b required 1", bus.req_ready); end
    repeat (4) begin @(negedge clk); if (MemWrite || bus.resp_valid) bad++; end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL rmw_quiet: bad_cycles=%0d required 0", bad); end
    do_req(1'b0, 2'b10, 1'b0, 7'h0C, 32'h0, rd, err, lat, nrd, nwr, wdo, r1, ra);
    checks++;
    if (rd !== 32'h8899AABB || err !== 1'b0) begin failures++; $display("FAIL rmw_word3: got %h required 8899aabb", rd); end
  endtask

  task automatic test_half_store();
    logic [31:0] rd, wdo, e_rd, e_wd; logic err, r1, ra, e_err; int lat, nrd, nwr, e_lat, e_nrd, e_nwr;
    model(1'b1, 2'b01, 1'b0, 7'h0C, 32'h00001234, e_rd, e_err, e_lat, e_nrd, e_nwr, e_wd);
    do_req(1'b1, 2'b01, 1'b0, 7'h0C, 32'h00001234, rd, err, lat, nrd, nwr, wdo, r1, ra);
    checks++;
    if (wdo !== 32'h88991234 || nwr != 1 || nrd != 1) begin failures++; $display("FAIL hstore_write: wdata=%h nwr=%0d nrd=%0d required 88991234 1 1", wdo, nwr, nrd); end
    checks++;
    if (lat != 4 || err !== 1'b0 || rd !== 32'h0) begin failures++; $display("FAIL hstore_resp: lat=%0d err=%b rdata=%h required 4 0 0", lat, err, rd); end
    do_req(1'b0, 2'b10, 1'b0, 7'h0C, 32'h0, rd, err, lat, nrd, nwr, wdo, r1, ra);
    checks++;
    if (rd !== 32'h88991234) begin failures++; $display("FAIL hstore_readback: got %h required 88991234", rd); end
  endtask

  task automatic test_word_store_top();
    logic [31:0] rd, wdo, e_rd, e_wd; logic err, r1, ra, e_err; int lat, nrd, nwr, e_lat, e_nrd, e_nwr;
    model(1'b1, 2'b10, 1'b0, 7'h7C, 32'hDEADBEEF, e_rd, e_err, e_lat, e_nrd, e_nwr, e_wd);
    do_req(1'b1, 2'b10, 1'b0, 7'h7C, 32'hDEADBEEF, rd, err, lat, nrd, nwr, wdo, r1, ra);
    checks++;
    if (lat != 2 || nrd != 0 || nwr != 1 || wdo !== 32'hDEADBEEF) begin
      failures++; $display("FAIL wstore_top: lat=%0d nrd=%0d nwr=%0d wdata=%h required 2 0 1 deadbeef", lat, nrd, nwr, wdo);
    end
    do_req(1'b0, 2'b10, 1'b1, 7'h7C, 32'h0, rd, err, lat, nrd, nwr, wdo, r1, ra);
    checks++;
    if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL wstore_readback: got %h required deadbeef", rd); end
  endtask

  task automatic test_random(input int n);
    logic [31:0] rd, wdo, e_rd, e_wd, wd; logic err, r1, ra, e_err; int lat, nrd, nwr, e_lat, e_nrd, e_nwr;
    logic [1:0] sz; logic [6:0] a; bit wr, uns;
    for (int i = 0; i < n; i++) begin
      wr = 1'($urandom); uns = 1'($urandom); sz = 2'($urandom_range(0, 3));
      a = 7'($urandom_range(0, 127)); wd = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      model(wr, sz, uns, a, wd, e_rd, e_err, e_lat, e_nrd, e_nwr, e_wd);
      do_req(wr, sz, uns, a, wd, rd, err, lat, nrd, nwr, wdo, r1, ra);
      checks++;
      if (rd !== e_rd || err !== e_err || lat != e_lat || nrd != e_nrd || nwr != e_nwr ||
          (e_nwr == 1 && wdo !== e_wd) || r1 !== 1'b0 || ra !== 1'b1) begin
        failures++;
        $display("FAIL rand_%0d wr=%0d sz=%0d a=%h: rdata=%h err=%b lat=%0d nrd=%0d nwr=%0d wdata=%h r1=%b after=%b required %h %b %0d %0d %0d %h 0 1",
                 i, wr, sz, a, rd, err, lat, nrd, nwr, wdo, r1, ra, e_rd, e_err, e_lat, e_nrd, e_nwr, e_wd);
      end
    end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      ref_mem[i] = (i == 3) ? 32'h8899AABB : $urandom;
      bd_we = 1'b1; bd_addr = 5'(i); bd_data = ref_mem[i];
      @(negedge clk);
    end
    bd_we = 1'b0;
    test_reset();
    test_loads();
    test_errors();
    test_reset_rmw();
    test_half_store();
    test_word_store_top();
    test_random(80);
    checks++;
    if (overlap != 0) begin failures++; $display("FAIL mem_overlap: cycles=%0d required 0", overlap); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
